// File: rtl/sram_bridge.sv
// sram_bridge: turns one core bus request (BUS_DW bits, byte-masked) into
// BUS_DW/16 timed asynchronous SRAM cycles on a 16-bit SRAM.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req, i_we               request (held until o_ack), 1 = write
//   i_addr                    byte address (low bits within a bus word ignored)
//   i_wdata, i_bmask          write data and byte enables
//   o_rdata                   last completed read data
//   o_ack, o_busy             completion pulse, transaction in progress
//   o_sram_addr, io_sram_dq   SRAM halfword address and data bus
//   o_sram_*_n                active-low SRAM controls
//
// Every SRAM-side output is a flop. Its next value is computed from the
// next FSM state, so a pin changes exactly when the FSM changes state.
module sram_bridge #(
  parameter int BUS_DW = 32,
  parameter int ADDR_W = 18,
  parameter int WAIT   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [31:0]           i_addr,
  input  logic [BUS_DW-1:0]     i_wdata,
  input  logic [BUS_DW/8-1:0]   i_bmask,
  output logic [BUS_DW-1:0]     o_rdata,
  output logic                  o_ack,
  output logic                  o_busy,
  output logic [ADDR_W-1:0]     o_sram_addr,
  inout  wire  [15:0]           io_sram_dq,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n,
  output logic                  o_sram_ub_n,
  output logic                  o_sram_lb_n
);

  localparam int BEATS = BUS_DW / 16;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [3:0]    WAIT_CNT  = 4'(WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RECOVER, ST_ACK} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [BUS_DW-1:0]   wdata_q, wdata_d;
  logic [BUS_DW/8-1:0] bmask_q, bmask_d;
  logic [ADDR_W-1:0]   base_q, base_d, base_in;
  logic [BUS_DW-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [15:0]         dq_out_q, dq_out_d;
  logic                ack_q, ack_d, busy_q, busy_d;
  logic [15:0]         wseg;
  logic [1:0]          mseg;
  logic                unused_addr;

  // Halfword address of the bus word: drop the byte bit and align to the
  // beat count. Bits above ADDR_W are discarded, so addresses wrap.
  assign base_in     = i_addr[ADDR_W:1] & ~ADDR_W'(BEATS - 1);
  assign unused_addr = ^{i_addr[31:ADDR_W+1], i_addr[0]};

  // Next-state process (control and request capture).
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    base_d  = base_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          state_d = ST_ACCESS;
          beat_d  = '0;
          cnt_d   = WAIT_CNT;
          we_d    = i_we;
          wdata_d = i_wdata;
          bmask_d = i_bmask;
          base_d  = base_in;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RECOVER;
          // Sample read data at the end of the last ACCESS cycle, while
          // oe_n is still low and the SRAM is driving.
          if (!we_q) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat_q == BW'(k)) rdata_d[16*k +: 16] = io_sram_dq;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECOVER: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_ACCESS;
          beat_d  = beat_q + BW'(1);
          cnt_d   = WAIT_CNT;
        end
      end
      default: state_d = ST_IDLE;  // ST_ACK: i_req is ignored here
    endcase
  end

  // Write data and byte enables of the beat the FSM is about to be in.
  always_comb begin
    wseg = '0;
    mseg = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_d == BW'(k)) begin
        wseg = wdata_d[16*k +: 16];
        mseg = bmask_d[2*k +: 2];
      end
    end
  end

  // Pin values for the next state; registered below so the pins are glitch-free.
  always_comb begin
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = dq_out_q;
    addr_d   = addr_q;
    ack_d    = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    case (state_d)
      ST_ACCESS, ST_RECOVER: begin
        ce_n_d = 1'b0;
        if (state_d == ST_ACCESS) begin
          addr_d = base_d + ADDR_W'(beat_d);
          oe_n_d = we_d;
          we_n_d = !we_d;
        end
        if (we_d) begin
          // Data and byte lanes stay put through RECOVER for hold time.
          ub_n_d   = ~mseg[1];
          lb_n_d   = ~mseg[0];
          dq_oe_d  = 1'b1;
          dq_out_d = wseg;
        end else begin
          ub_n_d = 1'b0;
          lb_n_d = 1'b0;
        end
      end
      ST_ACK:  ack_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      bmask_q  <= '0;
      base_q   <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      bmask_q  <= bmask_d;
      base_q   <= base_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign io_sram_dq  = dq_oe_q ? dq_out_q : 16'bz;
  assign o_sram_addr = addr_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_ub_n = ub_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_rdata     = rdata_q;
  assign o_ack       = ack_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_sram_bridge.sv
// Bench for sram_bridge: three instances (32-bit WAIT=1, 64-bit WAIT=0,
// 64-bit WAIT=15), each on its own behavioural async SRAM. Stimulus pushes
// the expected completion (ack cycle, read data, beat addresses and byte
// lanes) into a per-instance queue; a monitor pops and compares on o_ack.
module tb_sram_bridge;

  localparam int N = 3;

  typedef struct packed {
    logic        is_rd;
    logic [63:0] rdata;
    logic [31:0] ack_cyc;
    logic [17:0] base;
    logic [7:0]  ublb;    // beat k: {ub_n, lb_n} at bits [2k+1:2k]
  } exp_t;

  typedef struct packed {
    logic [17:0] a;
    logic [1:0]  m;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        req   [N];
  logic        we    [N];
  logic [31:0] addr  [N];
  logic [63:0] wdata [N];
  logic [7:0]  bmask [N];
  logic        ackv  [N];
  logic        busyv [N];

  exp_t  exp_q    [N][$];
  beat_t beat_log [N][$];

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int DWG = (gi == 0) ? 32 : 64;
    localparam int WTG = (gi == 0) ? 1 : ((gi == 1) ? 0 : 15);
    localparam int NB  = DWG / 16;

    logic [DWG-1:0] rd_l;
    logic           ack_l, busy_l, ce_l, oe_l, wen_l, ub_l, lb_l;
    logic [17:0]    saddr_l;
    wire  [15:0]    dq;
    logic [15:0]    mem [0:262143];
    logic           acc_prev = 1'b0;

    sram_bridge #(.BUS_DW(DWG), .ADDR_W(18), .WAIT(WTG)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (req[gi]),
      .i_we        (we[gi]),
      .i_addr      (addr[gi]),
      .i_wdata     (wdata[gi][DWG-1:0]),
      .i_bmask     (bmask[gi][DWG/8-1:0]),
      .o_rdata     (rd_l),
      .o_ack       (ack_l),
      .o_busy      (busy_l),
      .o_sram_addr (saddr_l),
      .io_sram_dq  (dq),
      .o_sram_ce_n (ce_l),
      .o_sram_oe_n (oe_l),
      .o_sram_we_n (wen_l),
      .o_sram_ub_n (ub_l),
      .o_sram_lb_n (lb_l)
    );

    assign ackv[gi]  = ack_l;
    assign busyv[gi] = busy_l;

    // Async SRAM: drives on read, latches enabled byte lanes while we_n is low.
    assign dq = (!ce_l && !oe_l && wen_l) ? mem[saddr_l] : 16'bz;
    initial for (int k = 0; k < 262144; k++) mem[k] = 16'h0000;
    initial forever begin
      @(posedge clk);
      if (!ce_l && !wen_l) begin
        if (!lb_l) mem[saddr_l][7:0]  = dq[7:0];
        if (!ub_l) mem[saddr_l][15:8] = dq[15:8];
      end
    end

    // Log address and byte lanes on the first cycle of each beat.
    initial forever begin
      @(negedge clk);
      if (!ce_l && (!oe_l || !wen_l) && !acc_prev)
        beat_log[gi].push_back(beat_t'{saddr_l, {ub_l, lb_l}});
      acc_prev = !ce_l && (!oe_l || !wen_l);
    end

    // Scoreboard monitor.
    initial forever begin
      exp_t  e;
      beat_t b;
      @(negedge clk);
      if (ack_l) begin
        if (exp_q[gi].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u%0d unexpected_ack: got ack=1 required ack=0 (cycle %0d)", gi, cyc);
        end else begin
          e = exp_q[gi].pop_front();
          $display("u%0d %s ack cycle=%0d base=%h rdata=%h", gi, e.is_rd ? "read " : "write",
                   cyc, e.base, rd_l);
          chk($sformatf("u%0d ack_cycle", gi), 64'(cyc), 64'(e.ack_cyc));
          if (e.is_rd) chk($sformatf("u%0d rdata", gi), 64'(rd_l), e.rdata);
          for (int k = 0; k < NB; k++) begin
            if (beat_log[gi].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL u%0d beat%0d_missing: got no beat required addr %h", gi, k,
                       e.base + 18'(k));
            end else begin
              b = beat_log[gi].pop_front();
              chk($sformatf("u%0d beat%0d_addr", gi, k), 64'(b.a), 64'(e.base + 18'(k)));
              chk($sformatf("u%0d beat%0d_ub_lb_n", gi, k), 64'(b.m), 64'(e.ublb[2*k +: 2]));
            end
          end
        end
      end
    end
  end

  task automatic wait_ack(input int i);
    bit got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      got = ackv[i];
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL u%0d ack_timeout: got no ack required ack within 300 cycles", i);
    end
  endtask

  // Issue one request in the next cycle; returns at the negedge of the ack cycle.
  task automatic run(input int i, input logic w, input logic [31:0] a, input logic [63:0] d,
                     input logic [7:0] m, input logic [63:0] erd, input logic [17:0] base,
                     input logic [7:0] ublb, input int lat, input bit hold);
    exp_t e;
    @(negedge clk);
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    bmask[i] = m;
    req[i]   = 1'b1;
    e.is_rd   = !w;
    e.rdata   = erd;
    e.ack_cyc = 32'(cyc + lat);
    e.base    = base;
    e.ublb    = ublb;
    exp_q[i].push_back(e);
    wait_ack(i);
    if (!hold) req[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; bmask[i] = '0;
    end
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_ack", 64'(g_dut[0].ack_l), 64'h0);
    chk("rst_busy", 64'(g_dut[0].busy_l), 64'h0);
    chk("rst_rdata", 64'(g_dut[0].rd_l), 64'h0);
    chk("rst_ctrl", 64'({g_dut[0].ce_l, g_dut[0].oe_l, g_dut[0].wen_l, g_dut[0].ub_l,
                         g_dut[0].lb_l}), 64'h1F);
    chk("rst_addr", 64'(g_dut[0].saddr_l), 64'h0);
    rst_n = 1'b1;

    // 32-bit, WAIT=1: ack in cycle 7.
    run(0, 1'b1, 32'h0000_0104, 64'hDEAD_BEEF, 8'h0F, 64'h0, 18'h00082, 8'h00, 7, 1'b0);
    chk("mem_0x82", 64'(g_dut[0].mem[18'h00082]), 64'hBEEF);
    chk("mem_0x83", 64'(g_dut[0].mem[18'h00083]), 64'hDEAD);
    run(0, 1'b0, 32'h0000_0104, 64'h0, 8'h00, 64'hDEAD_BEEF, 18'h00082, 8'h00, 7, 1'b0);
    run(0, 1'b0, 32'h0000_0107, 64'h0, 8'h00, 64'hDEAD_BEEF, 18'h00082, 8'h00, 7, 1'b0);

    // Byte mask 4'b0100: beat 0 no lanes, beat 1 lower lane only.
    run(0, 1'b1, 32'h0000_0200, 64'h1122_3344, 8'h04, 64'h0, 18'h00100, 8'h0B, 7, 1'b0);
    run(0, 1'b0, 32'h0000_0200, 64'h0, 8'h00, 64'h0022_0000, 18'h00100, 8'h00, 7, 1'b0);

    // Address wrap at the top of an 18-bit halfword space.
    run(0, 1'b1, 32'hFFFF_FFFC, 64'hCAFE_F00D, 8'h0F, 64'h0, 18'h3FFFE, 8'h00, 7, 1'b0);
    run(0, 1'b0, 32'hFFFF_FFFC, 64'h0, 8'h00, 64'hCAFE_F00D, 18'h3FFFE, 8'h00, 7, 1'b0);

    // Reset in beat 1 ACCESS of a write (cycle 4 after the request cycle).
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 32'h0000_0300; wdata[0] = 64'h55AA_55AA; bmask[0] = 8'h0F;
    req[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_we_n", 64'(g_dut[0].wen_l), 64'h0);
    chk("pre_rst_addr", 64'(g_dut[0].saddr_l), 64'h181);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_we_n", 64'(g_dut[0].wen_l), 64'h1);
    chk("midrst_ce_n", 64'(g_dut[0].ce_l), 64'h1);
    chk("midrst_busy", 64'(g_dut[0].busy_l), 64'h0);
    chk("midrst_rdata", 64'(g_dut[0].rd_l), 64'h0);
    chk("midrst_addr", 64'(g_dut[0].saddr_l), 64'h0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    beat_log[0].delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run(0, 1'b1, 32'h0000_0300, 64'h0102_0304, 8'h0F, 64'h0, 18'h00180, 8'h00, 7, 1'b0);
    run(0, 1'b0, 32'h0000_0300, 64'h0, 8'h00, 64'h0102_0304, 18'h00180, 8'h00, 7, 1'b0);

    // Back-to-back with i_req held: one IDLE cycle, next ACCESS at ack+2.
    run(0, 1'b1, 32'h0000_0400, 64'h89AB_CDEF, 8'h0F, 64'h0, 18'h00200, 8'h00, 7, 1'b1);
    chk("b2b_busy_in_ack", 64'(busyv[0]), 64'h1);
    fork
      run(0, 1'b0, 32'h0000_0400, 64'h0, 8'h00, 64'h89AB_CDEF, 18'h00200, 8'h00, 7, 1'b0);
      begin
        @(negedge clk);
        chk("b2b_busy_idle", 64'(busyv[0]), 64'h0);
        @(negedge clk);
        chk("b2b_busy_access", 64'(busyv[0]), 64'h1);
      end
    join

    // 64-bit, WAIT=0: ack in cycle 9.
    run(1, 1'b1, 32'h0000_1000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 18'h00800, 8'h00, 9, 1'b0);
    run(1, 1'b0, 32'h0000_1006, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 18'h00800, 8'h00, 9, 1'b0);

    // 64-bit, WAIT=15: ack in cycle 69; then a sparse-mask overwrite.
    run(2, 1'b1, 32'h0000_2008, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'h0, 18'h01004, 8'h00, 69, 1'b0);
    run(2, 1'b0, 32'h0000_2008, 64'h0, 8'h00, 64'hFEDC_BA98_7654_3210, 18'h01004, 8'h00, 69, 1'b0);
    run(2, 1'b1, 32'h0000_2008, 64'hAAAA_AAAA_AAAA_AAAA, 8'h81, 64'h0, 18'h01004, 8'h7E, 69, 1'b0);
    run(2, 1'b0, 32'h0000_2008, 64'h0, 8'h00, 64'hAADC_BA98_7654_32AA, 18'h01004, 8'h00, 69, 1'b0);

    repeat (5) @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("u%0d pending_expected", i), 64'(exp_q[i].size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
